// File: rtl/nvio3_pkg.sv
// Shared nvio3 definitions: register-file geometry and the write-back queue entry.
package nvio3_pkg;
    localparam int NREGS  = 32;
    localparam int RA_W   = $clog2(NREGS);
    localparam int WB_WID = 128;

    typedef struct packed {
        logic [RA_W-1:0]   ra;
        logic [WB_WID-1:0] data;
    } wb_ent_t;
endpackage

// File: rtl/gp_wb_fifo_mem.sv
// Write-back queue storage: two write ports, two asynchronous read ports, no reset.
module gp_wb_fifo_mem #(
    parameter int DEPTH = 8,
    parameter int EW    = 133
) (
    input  logic                     clk,
    input  logic                     we0,
    input  logic [$clog2(DEPTH)-1:0] wa0,
    input  logic [EW-1:0]            wd0,
    input  logic                     we1,
    input  logic [$clog2(DEPTH)-1:0] wa1,
    input  logic [EW-1:0]            wd1,
    input  logic [$clog2(DEPTH)-1:0] ra0,
    output logic [EW-1:0]            rd0,
    input  logic [$clog2(DEPTH)-1:0] ra1,
    output logic [EW-1:0]            rd1
);
    logic [EW-1:0] mem [DEPTH];

    // The queue never issues both writes to the same slot in one cycle.
    always_ff @(posedge clk) begin
        if (we0) mem[wa0] <= wd0;
        if (we1) mem[wa1] <= wd1;
    end

    assign rd0 = mem[ra0];
    assign rd1 = mem[ra1];
endmodule

// File: rtl/gp_wb_queue.sv
// Dual-producer write-back queue draining up to two entries per cycle into the register file.
// Optional macro GPWB_R0_FILTER_EN drops results destined for register 0 instead of queueing them.
module gp_wb_queue
    import nvio3_pkg::*;
#(
    parameter int WID   = 128,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   stall,
    input  logic                   v0,
    input  logic                   v1,
    output logic                   rdy0,
    output logic                   rdy1,
    input  logic [4:0]             ra_in0,
    input  logic [4:0]             ra_in1,
    input  logic [WID-1:0]         d0,
    input  logic [WID-1:0]         d1,
    output logic                   wr0,
    output logic                   wr1,
    output logic [4:0]             wa0,
    output logic [4:0]             wa1,
    output logic [WID-1:0]         i0,
    output logic [WID-1:0]         i1,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = RA_W + WID;

    // Same layout as wb_ent_t, sized by this instance's WID.
    typedef struct packed {
        logic [RA_W-1:0] ra;
        logic [WID-1:0]  data;
    } ent_t;

    logic [AW-1:0] wp, rp;
    logic          acc0, acc1, en0, en1;
    logic [1:0]    n_enq, n_pop;
    ent_t          ent0, ent1, wd_a, rd_a, rd_b;

    // Credits come from the registered count only; a same-cycle drain is not counted.
    assign rdy0  = count <= CW'(DEPTH - 1);
    assign rdy1  = count <= CW'(DEPTH - 2);
    assign empty = count == '0;
    assign full  = count == CW'(DEPTH);
    assign acc0  = v0 & rdy0;
    assign acc1  = v1 & rdy1;

`ifdef GPWB_R0_FILTER_EN
    assign en0 = acc0 & (ra_in0 != '0);
    assign en1 = acc1 & (ra_in1 != '0);
`else
    assign en0 = acc0;
    assign en1 = acc1;
`endif

    assign ent0  = {ra_in0, d0};
    assign ent1  = {ra_in1, d1};
    // Channel 0 takes the older slot; a lone channel 1 entry also lands at wp.
    assign wd_a  = en0 ? ent0 : ent1;
    assign n_enq = {1'b0, en0} + {1'b0, en1};
    assign n_pop = stall ? 2'd0 : (count >= CW'(2)) ? 2'd2 : count[1:0];

    gp_wb_fifo_mem #(.DEPTH(DEPTH), .EW(EW)) u_mem (
        .clk (clk),
        .we0 (en0 | en1),
        .wa0 (wp),
        .wd0 (wd_a),
        .we1 (en0 & en1),
        .wa1 (wp + AW'(1)),
        .wd1 (ent1),
        .ra0 (rp),
        .rd0 (rd_a),
        .ra1 (rp + AW'(1)),
        .rd1 (rd_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            wp    <= '0;
            rp    <= '0;
            wr0   <= 1'b0;
            wr1   <= 1'b0;
            wa0   <= '0;
            wa1   <= '0;
            i0    <= '0;
            i1    <= '0;
        end else if (flush) begin
            count <= '0;
            wp    <= '0;
            rp    <= '0;
            wr0   <= 1'b0;
            wr1   <= 1'b0;
        end else begin
            wp    <= wp + AW'(n_enq);
            rp    <= rp + AW'(n_pop);
            count <= count + CW'(n_enq) - CW'(n_pop);
            wr0   <= n_pop != 2'd0;
            wr1   <= n_pop == 2'd2;
            // Younger entry rides port 1, which wins in the register file on a same-address pair.
            if (n_pop != 2'd0) begin
                wa0 <= rd_a.ra;
                i0  <= rd_a.data;
            end
            if (n_pop == 2'd2) begin
                wa1 <= rd_b.ra;
                i1  <= rd_b.data;
            end
        end
    end
endmodule

// File: tb/tb_gp_wb_queue.sv
// Scoreboard bench for gp_wb_queue: driver feeds a queue-based reference model, monitor compares each cycle.
module tb_gp_wb_queue;
    localparam int WID   = 128;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int EW    = 5 + WID;
    localparam int RW    = 2 + CW + 1 + 2 * EW;

    logic                   clk = 1'b0;
    logic                   rst, flush, stall, v0, v1;
    logic                   rdy0, rdy1, wr0, wr1, empty, full;
    logic [4:0]             ra_in0, ra_in1, wa0, wa1;
    logic [WID-1:0]         d0, d1, i0, i1;
    logic [CW-1:0]          count;

    logic [RW-1:0] exp_q[$];
    logic [EW-1:0] mdl_q[$];
    int            vectors     = 0;
    int            miscompares = 0;

    always #5 clk = ~clk;

    gp_wb_queue #(.WID(WID), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .stall  (stall),
        .v0     (v0),
        .v1     (v1),
        .rdy0   (rdy0),
        .rdy1   (rdy1),
        .ra_in0 (ra_in0),
        .ra_in1 (ra_in1),
        .d0     (d0),
        .d1     (d1),
        .wr0    (wr0),
        .wr1    (wr1),
        .wa0    (wa0),
        .wa1    (wa1),
        .i0     (i0),
        .i1     (i1),
        .count  (count),
        .empty  (empty),
        .full   (full)
    );

    task automatic check(input string name, input logic [WID-1:0] act, input logic [WID-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic keep(input logic [4:0] ra);
`ifdef GPWB_R0_FILTER_EN
        return ra != 5'd0;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [WID-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Drive one cycle of inputs and record what the queue must show after the next edge.
    task automatic cycle(input logic r, input logic f, input logic s,
                         input logic a0, input logic a1,
                         input logic [4:0] ra0, input logic [4:0] ra1,
                         input logic [WID-1:0] x0, input logic [WID-1:0] x1);
        int            occ;
        int            np;
        logic [EW-1:0] e0, e1;
        @(negedge clk);
        rst = r; flush = f; stall = s; v0 = a0; v1 = a1;
        ra_in0 = ra0; ra_in1 = ra1; d0 = x0; d1 = x1;
        occ = mdl_q.size();
        np  = 0;
        e0  = '0;
        e1  = '0;
        if (r || f) begin
            mdl_q.delete();
        end else begin
            if (!s) np = (occ > 2) ? 2 : occ;
            if (np >= 1) e0 = mdl_q.pop_front();
            if (np == 2) e1 = mdl_q.pop_front();
            if (a0 && occ <= DEPTH - 1 && keep(ra0)) mdl_q.push_back({ra0, x0});
            if (a1 && occ <= DEPTH - 2 && keep(ra1)) mdl_q.push_back({ra1, x1});
        end
        exp_q.push_back({2'(np), CW'(mdl_q.size()), r, e0, e1});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: one expected record per clock edge, compared just after that edge.
    initial begin : monitor
        logic [RW-1:0] rec;
        logic [1:0]    enp;
        logic [CW-1:0] ecnt;
        logic          erst;
        logic [EW-1:0] ee0, ee1;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                rec = exp_q.pop_front();
                {enp, ecnt, erst, ee0, ee1} = rec;
                check("wr0", wr0, enp >= 2'd1);
                check("wr1", wr1, enp == 2'd2);
                check("count", count, ecnt);
                check("empty", empty, ecnt == '0);
                check("full", full, ecnt == CW'(DEPTH));
                check("rdy0", rdy0, ecnt <= CW'(DEPTH - 1));
                check("rdy1", rdy1, ecnt <= CW'(DEPTH - 2));
                if (enp >= 2'd1) begin
                    check("wa0", wa0, ee0[EW-1 -: 5]);
                    check("i0", i0, ee0[WID-1:0]);
                end
                if (enp == 2'd2) begin
                    check("wa1", wa1, ee1[EW-1 -: 5]);
                    check("i1", i1, ee1[WID-1:0]);
                end
                if (erst) begin
                    check("rst_wa0", wa0, 0);
                    check("rst_wa1", wa1, 0);
                    check("rst_i0", i0, 0);
                    check("rst_i1", i1, 0);
                end
            end
        end
    end

    initial begin : driver
        int sprob;
        int drained;
        rst = 1'b1; flush = 1'b0; stall = 1'b0; v0 = 1'b0; v1 = 1'b0;
        ra_in0 = '0; ra_in1 = '0; d0 = '0; d1 = '0;
        for (int k = 0; k < 3; k++) cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Single enqueue into an empty queue, then a same-register pair.
        cycle(0, 0, 0, 1, 0, 5'd5, 0, 'hA5, 0);
        idle(2);
        cycle(0, 0, 0, 1, 1, 5'd7, 5'd7, 1, 2);
        idle(2);

        // Fill under stall, then drain in FIFO order.
        for (int k = 0; k < 8; k++)
            cycle(0, 0, 1, 1, 1, 5'($urandom), 5'($urandom), rnd_data(), rnd_data());
        idle(6);

        // Reach count 7 so rdy1 drops while rdy0 is still high.
        for (int k = 0; k < 3; k++)
            cycle(0, 0, 1, 1, 1, 5'($urandom), 5'($urandom), rnd_data(), rnd_data());
        cycle(0, 0, 1, 1, 0, 5'd9, 0, rnd_data(), 0);
        cycle(0, 0, 1, 1, 1, 5'd10, 5'd11, rnd_data(), rnd_data());
        cycle(0, 0, 1, 1, 1, 5'd12, 5'd13, rnd_data(), rnd_data());
        idle(6);

        // Flush at count 6 with both producers valid.
        for (int k = 0; k < 3; k++)
            cycle(0, 0, 1, 1, 1, 5'($urandom), 5'($urandom), rnd_data(), rnd_data());
        cycle(0, 1, 0, 1, 1, 5'd3, 5'd4, rnd_data(), rnd_data());
        idle(3);

        // Register 0 destination.
        cycle(0, 0, 0, 1, 0, 5'd0, 0, 'h5A, 0);
        idle(2);

        // Reset in the middle of traffic, with flush also high.
        for (int k = 0; k < 3; k++)
            cycle(0, 0, 1, 1, 1, 5'($urandom), 5'($urandom), rnd_data(), rnd_data());
        cycle(0, 0, 0, 1, 1, 5'd1, 5'd2, rnd_data(), rnd_data());
        cycle(1, 1, 0, 1, 1, 5'd1, 5'd2, rnd_data(), rnd_data());
        idle(2);

        // Random traffic with stall pressure changing every 64 cycles.
        sprob = 3;
        for (int n = 0; n < 10000; n++) begin
            if (n % 64 == 0) sprob = $urandom_range(1, 8);
            cycle(($urandom_range(0, 1999) == 0), ($urandom_range(0, 299) == 0),
                  ($urandom_range(0, 9) < sprob),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                  5'($urandom), 5'($urandom), rnd_data(), rnd_data());
        end
        idle(6);

        drained = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #3;
            if (exp_q.size() == 0) begin
                drained = 1;
                break;
            end
        end
        check("scoreboard_drained", drained, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
